// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle ALU for the RISC-V datapath.
//   Single-cycle logic/arith/compare ops; shifts one bit per cycle.
//   Optional MUL (opcode 1010) via shift-add when ALU_MUL_EN is defined.
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   in_valid/in_ready    operand handshake (a, b, operation)
//   out_valid/out_ready  result handshake (Result, Zero, Overflow)
//   b[SHW-1:0]           shift amount for SLL/SRL/SRA
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // must hold WIDTH for the multiply count

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SLL = 4'b0011, OP_SRL = 4'b0100, OP_SRA = 4'b0101,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000,
                         OP_XOR = 4'b1001, OP_MUL = 4'b1010, OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef ALU_MUL_EN
    , MUL = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mpl_q, mpl_d, acc_q, acc_d, acc_nxt;
`endif

  logic [WIDTH-1:0] sum, diff, shift_nxt, fin_res;
  logic             fin_ovf, load;

  assign sum  = a + b;
  assign diff = a - b;

  // One-bit step of the work register in the direction of the latched op.
  always_comb begin
    shift_nxt = work_q;
    case (op_q)
      OP_SLL:  shift_nxt = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_nxt = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_nxt = work_q;
    endcase
  end

`ifdef ALU_MUL_EN
  assign acc_nxt = acc_q + (mpl_q[0] ? work_q : '0);
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    fin_res = '0;
    fin_ovf = 1'b0;
    load    = 1'b0;
`ifdef ALU_MUL_EN
    mpl_d   = mpl_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = operation;
        load    = 1'b1;
        state_d = DONE;
        case (operation)
          OP_AND:  fin_res = a & b;
          OP_OR:   fin_res = a | b;
          OP_XOR:  fin_res = a ^ b;
          OP_NOR:  fin_res = ~(a | b);
          OP_ADD: begin
            fin_res = sum;
            fin_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SUB: begin
            fin_res = diff;
            fin_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SLT:  fin_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          OP_SLTU: fin_res = {{(WIDTH-1){1'b0}}, (a < b)};
          OP_SLL, OP_SRL, OP_SRA: begin
            fin_res = a;  // used directly when shamt == 0
            if (b[SHW-1:0] != '0) begin
              load    = 1'b0;
              work_d  = a;
              cnt_d   = {1'b0, b[SHW-1:0]};
              state_d = SHIFT;
            end
          end
`ifdef ALU_MUL_EN
          OP_MUL: begin
            load    = 1'b0;
            work_d  = a;       // multiplicand, shifted left each step
            mpl_d   = b;       // multiplier, consumed LSB first
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = MUL;
          end
`endif
          default: fin_res = '0;
        endcase
      end
      SHIFT: begin
        work_d = shift_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin_res = shift_nxt;
          load    = 1'b1;
          state_d = DONE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        acc_d  = acc_nxt;
        work_d = {work_q[WIDTH-2:0], 1'b0};
        mpl_d  = {1'b0, mpl_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin_res = acc_nxt;
          load    = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      res_d  = fin_res;
      zero_d = (fin_res == '0);
      ovf_d  = fin_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mpl_q   <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`ifdef ALU_MUL_EN
      mpl_q   <= mpl_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0, b = '0;
  logic [3:0]  operation = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] Result;
  logic        Zero, Overflow;

  int          pass_cnt = 0, total = 0;
  int          lat;
  logic        irl;

  alu_seq #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation(operation), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present an op just after a rising edge, count edges (accept edge = 1)
  // until out_valid, and scramble the inputs after accept.
  task automatic do_op(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
    operation = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1; operation = 4'b1111;
    lat = 1; irl = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) irl = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consume the result (out_ready assumed high) and return to IDLE.
  task automatic pop();
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", Result, 64'd0);
    chk("rst_zero", 64'(Zero), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_op(4'b0000, 64'hAE, 64'h18C);
    chk("and_res", Result, 64'h8C); chk("and_lat", 64'(lat), 64'd1);
    chk("and_z", 64'(Zero), 64'd0); chk("and_o", 64'(Overflow), 64'd0);
    pop();
    chk("and_idle", 64'(in_ready), 64'd1);
    do_op(4'b0001, 64'hAE, 64'h18C);
    chk("or_res", Result, 64'h1AE); chk("or_lat", 64'(lat), 64'd1);
    chk("or_zo", {Zero, Overflow}, 64'd0);
    pop();
    do_op(4'b0010, 64'hAE, 64'h18C);
    chk("add_res", Result, 64'h23A); chk("add_lat", 64'(lat), 64'd1);
    chk("add_zo", {Zero, Overflow}, 64'd0);
    pop();
    do_op(4'b0110, 64'hAE, 64'h18C);
    chk("sub_res", Result, 64'hFFFFFFFFFFFFFF22); chk("sub_lat", 64'(lat), 64'd1);
    chk("sub_zo", {Zero, Overflow}, 64'd0);
    pop();
    do_op(4'b1100, 64'hAE, 64'h18C);
    chk("nor_res", Result, 64'hFFFFFFFFFFFFFE51); chk("nor_lat", 64'(lat), 64'd1);
    chk("nor_zo", {Zero, Overflow}, 64'd0);
    pop();

    do_op(4'b0110, 64'd5, 64'd5);
    chk("sub0_res", Result, 64'd0); chk("sub0_z", 64'(Zero), 64'd1);
    pop();
    do_op(4'b0010, 64'h7FFFFFFFFFFFFFFF, 64'd1);
    chk("addov_res", Result, 64'h8000000000000000); chk("addov_o", 64'(Overflow), 64'd1);
    pop();
    do_op(4'b0110, 64'h8000000000000000, 64'd1);
    chk("subov_res", Result, 64'h7FFFFFFFFFFFFFFF); chk("subov_o", 64'(Overflow), 64'd1);
    pop();
    do_op(4'b1001, 64'hF0F0, 64'h0FF0);
    chk("xor_res", Result, 64'hFF00);
    pop();
    do_op(4'b0111, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    chk("slt_res", Result, 64'd1);
    pop();
    do_op(4'b1000, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    chk("sltu_res", Result, 64'd0); chk("sltu_z", 64'(Zero), 64'd1);
    pop();
    do_op(4'b1111, 64'h55, 64'h66);
    chk("undef_res", Result, 64'd0); chk("undef_z", 64'(Zero), 64'd1);
    chk("undef_lat", 64'(lat), 64'd1);
    pop();

    do_op(4'b0101, 64'h8000000000000000, 64'd4);
    chk("sra_res", Result, 64'hF800000000000000); chk("sra_lat", 64'(lat), 64'd5);
    chk("sra_irlow", 64'(irl), 64'd1);
    pop();
    do_op(4'b0100, 64'hF0, 64'd4);
    chk("srl_res", Result, 64'h0F); chk("srl_lat", 64'(lat), 64'd5);
    pop();
    do_op(4'b0011, 64'h1234, 64'd0);
    chk("sll0_res", Result, 64'h1234); chk("sll0_lat", 64'(lat), 64'd1);
    pop();
    do_op(4'b0011, 64'd1, 64'd63);
    chk("sll63_res", Result, 64'h8000000000000000); chk("sll63_lat", 64'(lat), 64'd64);
    pop();

    out_ready = 1'b0;
    do_op(4'b0010, 64'd1, 64'd2);
    chk("bp_lat", 64'(lat), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_res", Result, 64'd3);
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_ir", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ir", 64'(in_ready), 64'd1);
    chk("bp_rel_ov", 64'(out_valid), 64'd0);

    operation = 4'b0100; a = 64'hFFFF_0000_0000_0000; b = 64'd40; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_ov", 64'(out_valid), 64'd0);
    chk("rstmid_res", Result, 64'd0);
    chk("rstmid_ir", 64'(in_ready), 64'd1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    do_op(4'b0010, 64'd10, 64'd20);
    chk("post_rst_add", Result, 64'd30); chk("post_rst_lat", 64'(lat), 64'd1);
    pop();

`ifdef ALU_MUL_EN
    do_op(4'b1010, 64'h1234, 64'h10);
    chk("mul_res", Result, 64'h12340); chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_o", 64'(Overflow), 64'd0);
    pop();
`else
    do_op(4'b1010, 64'h1234, 64'h10);
    chk("mulx_res", Result, 64'd0); chk("mulx_z", 64'(Zero), 64'd1);
    chk("mulx_lat", 64'(lat), 64'd1);
    pop();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
